// File: rtl/code_lock.sv
// Byte-serial combination lock: gathers CODE_BYTES bytes MSB first, unlocks on a
// match, counts consecutive failures and enforces a timed lockout after MAX_FAILS.
module code_lock #(
   parameter int unsigned                CODE_BYTES     = 4,
   parameter logic [8*CODE_BYTES-1:0]    CODE           = 32'hBAADC0DE,
   parameter int unsigned                MAX_FAILS      = 3,
   parameter int unsigned                LOCKOUT_CYCLES = 16,
   parameter int unsigned                GAP_CYCLES     = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [7:0]                         din,
   input  logic                               din_valid,
   input  logic                               relock,
   output logic                               unlocked,
   output logic                               lockout,
   output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

   localparam int unsigned IW = $clog2(CODE_BYTES + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
   localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);
   localparam int unsigned FW = $clog2(MAX_FAILS + 1);
   localparam int unsigned SW = 8 * CODE_BYTES;

   localparam logic [IW-1:0] LAST_IDX  = IW'(CODE_BYTES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);
   localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
   localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_UNLOCKED,
      S_LOCKOUT
   } state_t;

   state_t          state_q,    state_d;
   logic [IW-1:0]   idx_q,      idx_d;
   logic [GW-1:0]   gap_q,      gap_d;
   logic [SW-1:0]   shift_q,    shift_d;
   logic [FW-1:0]   fail_q,     fail_d;
   logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
   logic            unlocked_q, lockout_q;
   logic [SW-1:0]   entry;

   // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      gap_d      = gap_q;
      shift_d    = shift_q;
      fail_d     = fail_q;
      lock_cnt_d = lock_cnt_q;

      // Candidate entry including the byte on the bus; written this way so CODE_BYTES=1 works.
      entry      = shift_q << 8;
      entry[7:0] = din;

      unique case (state_q)
         S_IDLE, S_COLLECT: begin
            if (relock) begin
               state_d = S_IDLE;
               idx_d   = '0;
               gap_d   = '0;
               shift_d = '0;
            end else if (din_valid) begin
               gap_d = '0;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  shift_d = '0;
                  if (entry == CODE) begin
                     state_d = S_UNLOCKED;
                     fail_d  = '0;
                  end else if (fail_q == FAIL_LAST) begin
                     state_d    = S_LOCKOUT;
                     lock_cnt_d = LOCK_LOAD;
                     fail_d     = FAIL_MAX;
                  end else begin
                     state_d = S_IDLE;
                     fail_d  = fail_q + 1'b1;
                  end
               end else begin
                  state_d = S_COLLECT;
                  idx_d   = idx_q + 1'b1;
                  shift_d = entry;
               end
            end else if (state_q == S_COLLECT) begin
               // Sender stalled too long: drop the partial entry without counting a failure.
               if (gap_q == GAP_LAST) begin
                  state_d = S_IDLE;
                  idx_d   = '0;
                  gap_d   = '0;
                  shift_d = '0;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
         end

         S_UNLOCKED: begin
            if (relock) state_d = S_IDLE;
         end

         S_LOCKOUT: begin
            if (lock_cnt_q == '0) begin
               state_d = S_IDLE;
               fail_d  = '0;
            end else begin
               lock_cnt_d = lock_cnt_q - 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         gap_q      <= '0;
         shift_q    <= '0;
         fail_q     <= '0;
         lock_cnt_q <= '0;
         unlocked_q <= 1'b0;
         lockout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         shift_q    <= shift_d;
         fail_q     <= fail_d;
         lock_cnt_q <= lock_cnt_d;
         unlocked_q <= (state_d == S_UNLOCKED);
         lockout_q  <= (state_d == S_LOCKOUT);
      end
   end

   assign unlocked   = unlocked_q;
   assign lockout    = lockout_q;
   assign fail_count = fail_q;

endmodule
